// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by uart_tx and uart_rx.
// Holds the FSM state encoding, the parity modes and the parity function.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Widest legal word is 9 bits; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    function automatic logic parity_bit(input logic [8:0] data,
                                        input int         ptype);
        logic p;
        p = 1'b0;
        if (ptype == PARITY_EVEN) begin
            p = ^data;
        end else if (ptype == PARITY_ODD) begin
            p = ~^data;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter with synchronous clear.
// tick pulses on the last clk cycle of every bit period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt;

    // Count 0..CLKS_PER_BIT-1, wrapping on every bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises one word per valid/ready handshake onto a UART line.
// Frame is start, BITS_N data bits LSB-first, optional parity, stop bit(s).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int BITS_N       = 8,
    parameter int PARITY_TYPE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BITS_N-1:0] data_tx,
    input  logic              valid,
    output logic              ready,
    output logic              uart_out,
    output logic              busy
);

    localparam int IW = (BITS_N > 1) ? $clog2(BITS_N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BITS_N - 1);
    localparam bit HAS_PARITY = (PARITY_TYPE != PARITY_NONE);
    localparam bit TWO_STOPS  = (STOP_BITS == 2);

    uart_state_t       state;
    uart_state_t       state_next;
    logic [BITS_N-1:0] shreg;
    logic              par_bit;
    logic [IW-1:0]     idx;
    logic              stop_cnt;

    logic tick;
    logic timer_clear;
    logic line_next;
    logic load;
    logic shift;
    logic idx_inc;
    logic idx_clr;
    logic stop_set;
    logic stop_clr;

    assign ready       = (state == IDLE);
    assign busy        = ~ready;
    assign timer_clear = (state == IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .tick  (tick)
    );

    // State register and the glitch-free line flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            uart_out <= 1'b1;
        end else begin
            state    <= state_next;
            uart_out <= line_next;
        end
    end

    // Shift register, latched parity, bit index and stop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            par_bit  <= 1'b0;
            idx      <= '0;
            stop_cnt <= 1'b0;
        end else begin
            if (load) begin
                shreg   <= data_tx;
                par_bit <= parity_bit(9'(data_tx), PARITY_TYPE);
            end else if (shift) begin
                shreg <= shreg >> 1;
            end
            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + IW'(1);
            end
            if (stop_clr) begin
                stop_cnt <= 1'b0;
            end else if (stop_set) begin
                stop_cnt <= 1'b1;
            end
        end
    end

    // Next state and next line level; the line only moves on a bit boundary.
    always_comb begin
        state_next = state;
        line_next  = uart_out;
        load       = 1'b0;
        shift      = 1'b0;
        idx_inc    = 1'b0;
        idx_clr    = 1'b0;
        stop_set   = 1'b0;
        stop_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                line_next = 1'b1;
                if (valid) begin
                    state_next = START;
                    line_next  = 1'b0;
                    load       = 1'b1;
                    idx_clr    = 1'b1;
                    stop_clr   = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    line_next  = shreg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_clr = 1'b1;
                        if (HAS_PARITY) begin
                            state_next = PARITY;
                            line_next  = par_bit;
                        end else begin
                            state_next = STOP;
                            line_next  = 1'b1;
                        end
                    end else begin
                        idx_inc   = 1'b1;
                        line_next = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                    line_next  = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (TWO_STOPS && !stop_cnt) begin
                        stop_set = 1'b1;
                    end else begin
                        state_next = IDLE;
                        line_next  = 1'b1;
                        stop_clr   = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                line_next  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx across several configurations.
// Expected line levels come from a frame-bit queue built from the framing rules.
module tb_uart_tx;

    typedef bit bitq_t[$];

    typedef struct {
        int         k;
        logic [7:0] d;
        int         par;
        int         flen;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic       valid_in [6];
    logic [7:0] data_in  [6];
    logic       ready_w  [6];
    logic       line_w   [6];
    logic       busy_w   [6];

    int vec = 0;
    int bad = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(8), .BITS_N(8), .PARITY_TYPE(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .data_tx(data_in[0]), .valid(valid_in[0]),
        .ready(ready_w[0]), .uart_out(line_w[0]), .busy(busy_w[0]));
    uart_tx #(.CLKS_PER_BIT(8), .BITS_N(8), .PARITY_TYPE(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .data_tx(data_in[1]), .valid(valid_in[1]),
        .ready(ready_w[1]), .uart_out(line_w[1]), .busy(busy_w[1]));
    uart_tx #(.CLKS_PER_BIT(8), .BITS_N(8), .PARITY_TYPE(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .data_tx(data_in[2]), .valid(valid_in[2]),
        .ready(ready_w[2]), .uart_out(line_w[2]), .busy(busy_w[2]));
    uart_tx #(.CLKS_PER_BIT(8), .BITS_N(8), .PARITY_TYPE(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .data_tx(data_in[3]), .valid(valid_in[3]),
        .ready(ready_w[3]), .uart_out(line_w[3]), .busy(busy_w[3]));
    uart_tx #(.CLKS_PER_BIT(434), .BITS_N(8), .PARITY_TYPE(0), .STOP_BITS(1)) u4 (
        .clk(clk), .rst_n(rst_n), .data_tx(data_in[4]), .valid(valid_in[4]),
        .ready(ready_w[4]), .uart_out(line_w[4]), .busy(busy_w[4]));
    uart_tx #(.CLKS_PER_BIT(434), .BITS_N(8), .PARITY_TYPE(2), .STOP_BITS(1)) u5 (
        .clk(clk), .rst_n(rst_n), .data_tx(data_in[5]), .valid(valid_in[5]),
        .ready(ready_w[5]), .uart_out(line_w[5]), .busy(busy_w[5]));

    function automatic int cpb_of(int k);
        return (k >= 4) ? 434 : 8;
    endfunction

    function automatic int parity_of(int k);
        if (k == 1 || k == 5) return 2;
        if (k == 2) return 1;
        return 0;
    endfunction

    function automatic int stops_of(int k);
        return (k == 3) ? 2 : 1;
    endfunction

    // Line level for each bit slot of a frame, in transmission order.
    function automatic bitq_t frame_bits(int k, logic [7:0] d);
        bitq_t q;
        int    ones;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        ones = $countones(d);
        if (parity_of(k) == 2) q.push_back(ones % 2 == 1);
        if (parity_of(k) == 1) q.push_back(ones % 2 == 0);
        for (int i = 0; i < stops_of(k); i++) q.push_back(1'b1);
        return q;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (ready_w[k] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk1($sformatf("ready_timeout k%0d", k), 1'b0, 1'b1);
    endtask

    // One frame, checked every cycle; noisy mode wiggles data_tx and valid mid-frame.
    task automatic run_frame(input int k, input logic [7:0] d, input int par,
                             input int flen, input bit noisy);
        bitq_t q;
        int    cpb;
        int    slot;
        bit    ok;
        logic  e;
        q   = frame_bits(k, d);
        cpb = cpb_of(k);
        wait_ready(k, ok);
        if (!ok) return;
        data_in[k]  = d;
        valid_in[k] = 1'b1;
        @(negedge clk);
        valid_in[k] = 1'b0;
        for (int c = 0; c < flen; c++) begin
            slot = c / cpb;
            e    = (slot < q.size()) ? q[slot] : 1'b1;
            chk1($sformatf("line k%0d d%h c%0d", k, d, c), line_w[k], e);
            if (c == 0) chk1("ready_low", ready_w[k], 1'b0);
            if (par >= 0 && c == 9 * cpb + cpb / 2)
                chk1($sformatf("parity k%0d d%h", k, d), line_w[k], par[0]);
            if (noisy) begin
                data_in[k]  = 8'($urandom);
                valid_in[k] = (c == flen - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        chk1($sformatf("ready_back k%0d", k), ready_w[k], 1'b1);
        chk1($sformatf("busy_back k%0d", k), busy_w[k], 1'b0);
        valid_in[k] = 1'b0;
        @(negedge clk);
        chk1($sformatf("no_stray_line k%0d", k), line_w[k], 1'b1);
        chk1($sformatf("no_stray_ready k%0d", k), ready_w[k], 1'b1);
    endtask

    // valid held high across two words: second start must be F+1 clk after the first.
    task automatic back_to_back();
        bitq_t qa;
        bitq_t qb;
        int    f;
        bit    ok;
        logic  e;
        qa = frame_bits(0, 8'hA5);
        qb = frame_bits(0, 8'h3C);
        f  = qa.size() * 8;
        wait_ready(0, ok);
        if (!ok) return;
        data_in[0]  = 8'hA5;
        valid_in[0] = 1'b1;
        @(negedge clk);
        data_in[0] = 8'h3C;
        for (int c = 0; c <= 2 * f; c++) begin
            if (c < f) e = qa[c / 8];
            else if (c == f) e = 1'b1;
            else e = qb[(c - f - 1) / 8];
            chk1($sformatf("b2b c%0d", c), line_w[0], e);
            if (c == f) chk1("b2b_ready", ready_w[0], 1'b1);
            if (c == f + 1) valid_in[0] = 1'b0;
            if (c > f + 1) data_in[0] = 8'($urandom);
            @(negedge clk);
        end
        chk1("b2b_end_ready", ready_w[0], 1'b1);
    endtask

    // Behavioural mid-bit sampling receiver.
    task automatic rx_frame(input int k, output logic [7:0] d, output bit perr,
                            output bit ferr, output bit tmo);
        int   cpb;
        logic p;
        bit   seen;
        cpb  = cpb_of(k);
        d    = '0;
        perr = 1'b0;
        ferr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            if (line_w[k] === 1'b0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tmo = !seen;
        if (tmo) return;
        repeat (cpb / 2) @(negedge clk);
        if (line_w[k] !== 1'b0) ferr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat (cpb) @(negedge clk);
            d[i] = line_w[k];
        end
        if (parity_of(k) != 0) begin
            repeat (cpb) @(negedge clk);
            p = line_w[k];
            if (parity_of(k) == 2) perr = (($countones(d) + int'(p)) % 2) != 0;
            else perr = (($countones(d) + int'(p)) % 2) != 1;
        end
        repeat (cpb) @(negedge clk);
        if (line_w[k] !== 1'b1) ferr = 1'b1;
    endtask

    task automatic loopback(input int k, input logic [7:0] d);
        logic [7:0] got;
        bit         perr;
        bit         ferr;
        bit         tmo;
        fork
            begin
                bit ok;
                wait_ready(k, ok);
                if (ok) begin
                    data_in[k]  = d;
                    valid_in[k] = 1'b1;
                    @(negedge clk);
                    valid_in[k] = 1'b0;
                    data_in[k]  = ~d;
                end
            end
            rx_frame(k, got, perr, ferr, tmo);
        join
        chk1($sformatf("lb_timeout k%0d", k), tmo, 1'b0);
        chk8($sformatf("lb_data k%0d", k), got, d);
        chk1($sformatf("lb_parity_err k%0d", k), perr, 1'b0);
        chk1($sformatf("lb_frame_err k%0d", k), ferr, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tab[10];
        tab[0] = '{0, 8'hA5, -1, 80};
        tab[1] = '{0, 8'h00, -1, 80};
        tab[2] = '{0, 8'hFF, -1, 80};
        tab[3] = '{1, 8'h07,  1, 88};
        tab[4] = '{2, 8'h07,  0, 88};
        tab[5] = '{1, 8'hA5,  0, 88};
        tab[6] = '{2, 8'hA5,  1, 88};
        tab[7] = '{3, 8'hA5, -1, 88};
        tab[8] = '{3, 8'h3C, -1, 88};
        tab[9] = '{4, 8'hA5, -1, 4340};

        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            valid_in[k] = 1'b0;
            data_in[k]  = 8'h00;
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            chk1($sformatf("rst_line k%0d", k), line_w[k], 1'b1);
            chk1($sformatf("rst_ready k%0d", k), ready_w[k], 1'b1);
            chk1($sformatf("rst_busy k%0d", k), busy_w[k], 1'b0);
        end

        for (int i = 0; i < 10; i++)
            run_frame(tab[i].k, tab[i].d, tab[i].par, tab[i].flen, 1'b0);

        for (int i = 0; i < 24; i++) begin
            int         k;
            logic [7:0] d;
            bitq_t      q;
            k = $urandom_range(0, 3);
            d = 8'($urandom);
            q = frame_bits(k, d);
            run_frame(k, d, -1, q.size() * cpb_of(k), 1'b1);
        end

        back_to_back();

        // Reset in the middle of a start bit pulls the line high at once.
        begin
            bit ok;
            wait_ready(0, ok);
            data_in[0]  = 8'hA5;
            valid_in[0] = 1'b1;
            @(negedge clk);
            valid_in[0] = 1'b0;
            repeat (3) @(negedge clk);
            chk1("mid_start_low", line_w[0], 1'b0);
            #1 rst_n = 1'b0;
            #1;
            chk1("mid_rst_line", line_w[0], 1'b1);
            chk1("mid_rst_ready", ready_w[0], 1'b1);
            chk1("mid_rst_busy", busy_w[0], 1'b0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                chk1($sformatf("post_rst_idle c%0d", c), line_w[0], 1'b1);
            end
        end

        // valid rising together with reset must not start a frame.
        valid_in[0] = 1'b1;
        data_in[0]  = 8'h00;
        rst_n       = 1'b0;
        @(negedge clk);
        valid_in[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk1($sformatf("rst_valid_line c%0d", c), line_w[0], 1'b1);
            chk1($sformatf("rst_valid_ready c%0d", c), ready_w[0], 1'b1);
        end

        loopback(4, 8'hA5);
        loopback(4, 8'h3C);
        loopback(5, 8'hA5);
        loopback(5, 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
